// File: rtl/regi_pkg.sv
// Shared definitions for the regi step counter family.
//   MODE_WRAP / MODE_MOD / MODE_SAT : overflow-mode selectors for the MODE parameter
//   state_t                         : output-stream FSM states (S_INIT, S_RUN)
package regi_pkg;

    localparam int MODE_WRAP = 0;  // wrap at 2^W
    localparam int MODE_MOD  = 1;  // wrap at MAX+1
    localparam int MODE_SAT  = 2;  // clamp at 0 / MAX

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/regi_step_next.sv
// Combinational next-value computation for the step counter.
// Ports:
//   cur  in  W  current count
//   step in  W  step magnitude
//   dir  in  1  0 = up, 1 = down
//   nxt  out W  advanced value under the selected overflow mode
//   flag out 1  advance wrapped (MODE_WRAP / MODE_MOD) or clamped (MODE_SAT)
module regi_step_next
    import regi_pkg::*;
#(
    parameter int             W    = 32,
    parameter int             MODE = MODE_WRAP,
    parameter logic [W-1:0]   MAX  = '1
) (
    input  logic [W-1:0] cur,
    input  logic [W-1:0] step,
    input  logic         dir,
    output logic [W-1:0] nxt,
    output logic         flag
);

    // All arithmetic is carried at W+1 bits so the carry out of an up-count
    // and the borrow of a down-count (bit W set = cur < step) are both visible.
    logic [W:0]   sum;
    logic [W:0]   diff;
    logic [W:0]   modulus;
    logic [W-1:0] mod_up;
    logic [W-1:0] mod_dn;

    assign sum     = {1'b0, cur} + {1'b0, step};
    assign diff    = {1'b0, cur} - {1'b0, step};
    assign modulus = {1'b0, MAX} + {{W{1'b0}}, 1'b1};

    // With step <= MAX both wrapped results land back inside 0..MAX,
    // so dropping bit W is exact.
    assign mod_up  = W'(sum - modulus);
    assign mod_dn  = W'(diff + modulus);

    always_comb begin
        nxt  = cur;
        flag = 1'b0;
        if (MODE == MODE_MOD) begin
            if (!dir) begin
                if (sum > {1'b0, MAX}) begin
                    nxt  = mod_up;
                    flag = 1'b1;
                end else begin
                    nxt  = sum[W-1:0];
                end
            end else begin
                if (diff[W]) begin
                    nxt  = mod_dn;
                    flag = 1'b1;
                end else begin
                    nxt  = diff[W-1:0];
                end
            end
        end else if (MODE == MODE_SAT) begin
            if (!dir) begin
                if (sum > {1'b0, MAX}) begin
                    nxt  = MAX;
                    flag = 1'b1;
                end else begin
                    nxt  = sum[W-1:0];
                end
            end else begin
                if (diff[W]) begin
                    nxt  = '0;
                    flag = 1'b1;
                end else begin
                    nxt  = diff[W-1:0];
                end
            end
        end else begin
            if (!dir) begin
                nxt  = sum[W-1:0];
                flag = sum[W];
            end else begin
                nxt  = diff[W-1:0];
                flag = diff[W];
            end
        end
    end

endmodule

// File: rtl/regi_step_counter.sv
// W-bit up/down counter with programmable step and a val/rdy output stream.
// Each value is held on out until the sink takes it; only then (with en)
// does the counter advance. A load replaces the count in one edge.
// Ports:
//   clk       in  1  clock, all state on posedge
//   reset     in  1  synchronous, active-high
//   en        in  1  advance enable; 0 makes a transfer repeat the value
//   dir       in  1  0 = count up, 1 = count down
//   step      in  W  increment per transfer
//   load_val  in  1  load request, wins over advance
//   load_data in  W  value to load (clamped to MAX in MODE_MOD / MODE_SAT)
//   out       out W  current count
//   out_val   out 1  out is valid (high exactly in S_RUN)
//   out_rdy   in  1  sink accepts out
//   tc        out 1  one-cycle pulse after an advance that wrapped or clamped
//
// Handshake: a transfer happens on a posedge where out_val && out_rdy are
// both high. While out_rdy is low, out and out_val do not change except
// through load or reset.
module regi_step_counter
    import regi_pkg::*;
#(
    parameter int           W         = 32,
    parameter int           MODE      = MODE_WRAP,
    parameter logic [W-1:0] MAX       = '1,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         dir,
    input  logic [W-1:0] step,
    input  logic         load_val,
    input  logic [W-1:0] load_data,
    output logic [W-1:0] out,
    output logic         out_val,
    input  logic         out_rdy,
    output logic         tc
);

    state_t       state;
    state_t       state_nxt;
    logic         fire;
    logic         advance;
    logic [W-1:0] step_nxt;
    logic         step_flag;
    logic [W-1:0] load_clamped;

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state and stream-valid decode
    always_comb begin
        state_nxt = state;
        out_val   = 1'b0;
        case (state)
            S_INIT: state_nxt = S_RUN;
            S_RUN: begin
                state_nxt = S_RUN;
                out_val   = 1'b1;
            end
        endcase
    end

    assign fire    = out_val & out_rdy;
    assign advance = fire & en;

    always_comb begin
        load_clamped = load_data;
        if (MODE != MODE_WRAP && load_data > MAX) begin
            load_clamped = MAX;
        end
    end

    regi_step_next #(
        .W    (W),
        .MODE (MODE),
        .MAX  (MAX)
    ) u_next (
        .cur  (out),
        .step (step),
        .dir  (dir),
        .nxt  (step_nxt),
        .flag (step_flag)
    );

    // Count register. A load in the same cycle as a transfer still lets the
    // sink consume the current value; the loaded value is what it sees next.
    always_ff @(posedge clk) begin
        if (reset) begin
            out <= RESET_VAL;
            tc  <= 1'b0;
        end else if (out_val && load_val) begin
            out <= load_clamped;
            tc  <= 1'b0;
        end else if (advance) begin
            out <= step_nxt;
            tc  <= step_flag;
        end else begin
            tc  <= 1'b0;
        end
    end

endmodule
